// File: rtl/store_unit.sv
// rtl/store_unit.sv - RV32I store path: alignment check, lane replication, single-beat AHB-lite write.
// Optional data-phase timeout abort enabled by defining STORE_TIMEOUT_EN.
module store_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        st_valid_in,
  input  logic [1:0]  st_size_in,
  input  logic [31:0] iaddr_in,
  input  logic [31:0] rs2_in,
  input  logic        ahb_ready_in,
  input  logic        ahb_resp_in,
  output logic        dmwr_req_out,
  output logic [31:0] dmaddr_out,
  output logic [3:0]  dmwr_mask_out,
  output logic [31:0] dmdata_out,
  output logic        st_busy_out,
  output logic        st_done_out,
  output logic        st_misalign_out,
  output logic        st_err_out
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t      state_q, state_d;
  logic [29:0] addr_q;
  logic [3:0]  mask_q, mask_d;
  logic [31:0] data_q, data_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        mis_q, mis_d;
  logic        misaligned;
  logic        accept;
  logic        tmo_hit;

  assign misaligned = ((st_size_in == 2'b01) && iaddr_in[0]) ||
                      (st_size_in[1] && (iaddr_in[1:0] != 2'b00));
  assign accept     = (state_q == IDLE) && st_valid_in && !misaligned;

  // Replicate the source onto every lane so the mask alone selects the bytes written.
  always_comb begin
    data_d = rs2_in;
    mask_d = 4'b1111;
    case (st_size_in)
      2'b00: begin
        data_d = {4{rs2_in[7:0]}};
        mask_d = 4'b0001 << iaddr_in[1:0];
      end
      2'b01: begin
        data_d = {2{rs2_in[15:0]}};
        mask_d = iaddr_in[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        data_d = rs2_in;
        mask_d = 4'b1111;
      end
    endcase
  end

`ifdef STORE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] tmo_q;

  assign tmo_hit = (tmo_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      tmo_q <= '0;
    end else if ((state_q == ADDR) && ahb_ready_in) begin
      tmo_q <= '0;
    end else if ((state_q == DATA) && !ahb_ready_in) begin
      tmo_q <= tmo_q + 1'b1;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT_CYCLES > 0);
  assign tmo_hit    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    mis_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (st_valid_in) begin
          if (misaligned) mis_d = 1'b1;
          else            state_d = ADDR;
        end
      end
      ADDR: begin
        if (ahb_ready_in) state_d = DATA;
      end
      DATA: begin
        if (ahb_ready_in) begin
          state_d = IDLE;
          if (ahb_resp_in) err_d  = 1'b1;
          else             done_d = 1'b1;
        end else if (tmo_hit) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      addr_q  <= '0;
      mask_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      err_q   <= err_d;
      mis_q   <= mis_d;
      if (accept) begin
        addr_q <= iaddr_in[31:2];
        mask_q <= mask_d;
        data_q <= data_d;
      end
    end
  end

  assign dmwr_req_out    = (state_q == ADDR);
  assign dmaddr_out      = (state_q == ADDR) ? {addr_q, 2'b00} : 32'h0;
  assign dmwr_mask_out   = (state_q == ADDR) ? mask_q : 4'b0000;
  assign dmdata_out      = (state_q == DATA) ? data_q : 32'h0;
  assign st_busy_out     = (state_q != IDLE);
  assign st_done_out     = done_q;
  assign st_err_out      = err_q;
  assign st_misalign_out = mis_q;

endmodule

// File: tb/tb_store_unit.sv
// tb/tb_store_unit.sv - directed self-checking bench for store_unit.
// Timeout case follows STORE_TIMEOUT_EN when defined for the build.
module tb_store_unit;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        st_valid_in;
  logic [1:0]  st_size_in;
  logic [31:0] iaddr_in;
  logic [31:0] rs2_in;
  logic        ahb_ready_in;
  logic        ahb_resp_in;
  logic        dmwr_req_out;
  logic [31:0] dmaddr_out;
  logic [3:0]  dmwr_mask_out;
  logic [31:0] dmdata_out;
  logic        st_busy_out;
  logic        st_done_out;
  logic        st_misalign_out;
  logic        st_err_out;

  int checks = 0;
  int errors = 0;

  store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .st_valid_in(st_valid_in),
    .st_size_in(st_size_in), .iaddr_in(iaddr_in), .rs2_in(rs2_in),
    .ahb_ready_in(ahb_ready_in), .ahb_resp_in(ahb_resp_in),
    .dmwr_req_out(dmwr_req_out), .dmaddr_out(dmaddr_out),
    .dmwr_mask_out(dmwr_mask_out), .dmdata_out(dmdata_out),
    .st_busy_out(st_busy_out), .st_done_out(st_done_out),
    .st_misalign_out(st_misalign_out), .st_err_out(st_err_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic request(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] data);
    st_valid_in = 1'b1;
    st_size_in  = size;
    iaddr_in    = addr;
    rs2_in      = data;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, " pulses"}, {29'd0, st_done_out, st_err_out, st_misalign_out}, 32'd0);
    check({tag, " req"}, {31'd0, dmwr_req_out}, 32'd0);
    check({tag, " busy"}, {31'd0, st_busy_out}, 32'd0);
  endtask

  initial begin
    rst_in = 1'b1; st_valid_in = 1'b0; st_size_in = 2'b00;
    iaddr_in = 32'h0; rs2_in = 32'h0; ahb_ready_in = 1'b1; ahb_resp_in = 1'b0;
    tick(); tick();
    check_quiet("reset");
    check("reset addr", dmaddr_out, 32'h0);
    check("reset data", dmdata_out, 32'h0);
    check("reset mask", {28'd0, dmwr_mask_out}, 32'h0);
    rst_in = 1'b0;
    tick();

    // SB 0x1003, zero wait
    request(2'b00, 32'h0000_1003, 32'hAABB_CCDD);
    tick();
    st_valid_in = 1'b0;
    check("sb n1 req", {31'd0, dmwr_req_out}, 32'd1);
    check("sb n1 busy", {31'd0, st_busy_out}, 32'd1);
    check("sb n1 addr", dmaddr_out, 32'h0000_1000);
    check("sb n1 mask", {28'd0, dmwr_mask_out}, 32'h8);
    check("sb n1 data", dmdata_out, 32'h0);
    tick();
    check("sb n2 req", {31'd0, dmwr_req_out}, 32'd0);
    check("sb n2 addr", dmaddr_out, 32'h0);
    check("sb n2 data", dmdata_out, 32'hDDDD_DDDD);
    check("sb n2 busy", {31'd0, st_busy_out}, 32'd1);
    tick();
    check("sb n3 done", {31'd0, st_done_out}, 32'd1);
    check("sb n3 busy", {31'd0, st_busy_out}, 32'd0);
    check("sb n3 data", dmdata_out, 32'h0);
    tick();
    check("sb n4 done", {31'd0, st_done_out}, 32'd0);

    // SH 0x2002 with two DATA wait states
    request(2'b01, 32'h0000_2002, 32'h1234_5678);
    tick();
    st_valid_in = 1'b0;
    check("sh n1 mask", {28'd0, dmwr_mask_out}, 32'hC);
    check("sh n1 addr", dmaddr_out, 32'h0000_2000);
    tick();
    ahb_ready_in = 1'b0;
    check("sh n2 data", dmdata_out, 32'h5678_5678);
    tick();
    check("sh n3 busy", {31'd0, st_busy_out}, 32'd1);
    check("sh n3 done", {31'd0, st_done_out}, 32'd0);
    tick();
    ahb_ready_in = 1'b1;
    check("sh n4 busy", {31'd0, st_busy_out}, 32'd1);
    check("sh n4 data", dmdata_out, 32'h5678_5678);
    tick();
    check("sh n5 done", {31'd0, st_done_out}, 32'd1);
    check("sh n5 busy", {31'd0, st_busy_out}, 32'd0);
    tick();

    // Misaligned SW and SH at 0x3001
    for (int k = 0; k < 2; k++) begin
      request((k == 0) ? 2'b10 : 2'b01, 32'h0000_3001, 32'hFFFF_FFFF);
      tick();
      st_valid_in = 1'b0;
      check("mis n1 flag", {31'd0, st_misalign_out}, 32'd1);
      check("mis n1 req", {31'd0, dmwr_req_out}, 32'd0);
      check("mis n1 busy", {31'd0, st_busy_out}, 32'd0);
      tick();
      check_quiet("mis n2");
    end

    // SW 0x4000 with bus error
    request(2'b10, 32'h0000_4000, 32'hCAFE_F00D);
    tick();
    st_valid_in = 1'b0;
    check("err n1 mask", {28'd0, dmwr_mask_out}, 32'hF);
    tick();
    ahb_resp_in = 1'b1;
    check("err n2 data", dmdata_out, 32'hCAFE_F00D);
    tick();
    ahb_resp_in = 1'b0;
    check("err n3 err", {31'd0, st_err_out}, 32'd1);
    check("err n3 done", {31'd0, st_done_out}, 32'd0);
    check("err n3 busy", {31'd0, st_busy_out}, 32'd0);
    tick();
    check_quiet("err n4");

    // Back-to-back SW, valid held busy with a decoy address
    request(2'b10, 32'h0000_5000, 32'h1111_1111);
    tick();
    request(2'b10, 32'h0000_9990, 32'h9999_9999);
    check("b2b a n1 addr", dmaddr_out, 32'h0000_5000);
    tick();
    check("b2b a n2 data", dmdata_out, 32'h1111_1111);
    check("b2b a n2 req", {31'd0, dmwr_req_out}, 32'd0);
    tick();
    request(2'b10, 32'h0000_5004, 32'h2222_2222);
    check("b2b a done", {31'd0, st_done_out}, 32'd1);
    tick();
    st_valid_in = 1'b0;
    check("b2b b n1 addr", dmaddr_out, 32'h0000_5004);
    check("b2b b n1 done", {31'd0, st_done_out}, 32'd0);
    tick();
    check("b2b b n2 data", dmdata_out, 32'h2222_2222);
    tick();
    check("b2b b done", {31'd0, st_done_out}, 32'd1);
    tick();
    check_quiet("b2b idle");

    // Reset during DATA
    request(2'b10, 32'h0000_6000, 32'h3333_3333);
    tick();
    st_valid_in = 1'b0;
    tick();
    rst_in = 1'b1;
    check("rst n2 data", dmdata_out, 32'h3333_3333);
    tick();
    rst_in = 1'b0;
    check_quiet("rst n3");
    check("rst n3 data", dmdata_out, 32'h0);
    tick();
    check_quiet("rst n4");

    // DATA stall with ready held low
    request(2'b10, 32'h0000_7000, 32'h4444_4444);
    tick();
    st_valid_in = 1'b0;
    tick();
    ahb_ready_in = 1'b0;
`ifdef STORE_TIMEOUT_EN
    tick(); tick(); tick();
    check("tmo n5 busy", {31'd0, st_busy_out}, 32'd1);
    check("tmo n5 err", {31'd0, st_err_out}, 32'd0);
    tick();
    check("tmo n6 err", {31'd0, st_err_out}, 32'd1);
    check("tmo n6 busy", {31'd0, st_busy_out}, 32'd0);
    check("tmo n6 data", dmdata_out, 32'h0);
    ahb_ready_in = 1'b1;
    tick();
    check_quiet("tmo n7");
`else
    for (int k = 0; k < 10; k++) tick();
    check("hold busy", {31'd0, st_busy_out}, 32'd1);
    check("hold data", dmdata_out, 32'h4444_4444);
    check("hold err", {31'd0, st_err_out}, 32'd0);
    ahb_ready_in = 1'b1;
    tick();
    check("hold done", {31'd0, st_done_out}, 32'd1);
`endif
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/store_unit.md
# store_unit

RV32I data-memory write path: the store-side counterpart of the load unit. Accepts a store request from the execute stage, checks alignment, replicates rs2 data onto the correct byte lanes with a byte-write mask, and runs a single-beat write transfer on the data-memory AHB-lite port. Stalls the pipeline until the write completes and reports completion, misalignment and bus error to the trap logic.

## Interface
- TIMEOUT_CYCLES, 16: maximum data-phase wait cycles before abort (used only with STORE_TIMEOUT_EN); minimum 1.
- clk_in  input  1  core clock; all state updates on rising edge.
- rst_in  input  1  reset; synchronous, active-high.
- st_valid_in  input  1  store request from execute stage; sampled only in IDLE.
- st_size_in  input  2  00 byte (SB), 01 half (SH), 10/11 word (SW).
- iaddr_in  input  32  effective byte address.
- rs2_in  input  32  store source data.
- ahb_ready_in  input  1  HREADY from data memory.
- ahb_resp_in  input  1  HRESP; 0 OKAY, 1 ERROR (same encoding as load path).
- dmwr_req_out  output  1  address-phase valid (HTRANS NONSEQ, HWRITE=1).
- dmaddr_out  output  32  word-aligned address {addr[31:2],2'b00}.
- dmwr_mask_out  output  4  byte-lane write enables, bit n = byte lane n.
- dmdata_out  output  32  lane-replicated write data.
- st_busy_out  output  1  stall request to pipeline.
- st_done_out  output  1  one-cycle pulse: write completed OKAY.
- st_misalign_out  output  1  one-cycle pulse: store address misaligned, no bus transfer.
- st_err_out  output  1  one-cycle pulse: bus error or timeout, write aborted.

## Operation
- States: IDLE, ADDR, DATA. Reset → IDLE.
- IDLE, st_valid_in=1: alignment check. Misaligned = (half and addr[0]=1) or (word and addr[1:0]≠00). Misaligned → pulse st_misalign_out next cycle, stay IDLE. Aligned → latch address, lane data and mask, go ADDR.
- Lane formation (latched at accept): byte: data {4{rs2[7:0]}}, mask 0001<<addr[1:0]. Half: data {2{rs2[15:0]}}, mask 0011 (addr[1]=0) or 1100 (addr[1]=1). Word: data rs2, mask 1111.
- ADDR: dmwr_req_out=1, dmaddr_out and dmwr_mask_out driven. ahb_ready_in=1 → DATA; else hold ADDR with address stable.
- DATA: dmwr_req_out=0, dmdata_out driven with latched data. ahb_ready_in=1 and ahb_resp_in=0 → pulse st_done_out, IDLE. ahb_ready_in=1 and ahb_resp_in=1 → pulse st_err_out, IDLE. ahb_ready_in=0 → hold DATA.
- Outside their phases: dmwr_req_out=0, dmaddr_out=0, dmwr_mask_out=0, dmdata_out=0.
- st_busy_out=1 in ADDR and DATA; 0 in IDLE.
- Pulses are mutually exclusive and never coincide with another pulse in the next cycle.

## Timing
- Reset values: all outputs 0, state IDLE, timeout counter 0.
- Reset mid-transfer (ADDR or DATA): next cycle IDLE, no done/err pulse, bus outputs 0.
- Zero-wait store: accept cycle N, ADDR N+1, DATA N+2, st_done_out high N+3. Busy high N+1..N+2.
- Each wait state in ADDR or DATA adds one cycle.
- New request accepted in the cycle a done/err/misalign pulse is high (state already IDLE): back-to-back stores, 3-cycle pitch.
- Misaligned: accept cycle N, st_misalign_out high N+1, no bus activity, busy never asserted.
- st_valid_in ignored while not IDLE.

## Configuration
- STORE_TIMEOUT_EN defined: counter clears on entry to DATA, increments each DATA cycle with ahb_ready_in=0; reaching TIMEOUT_CYCLES → pulse st_err_out, IDLE, dmdata_out 0.
- Not defined: no counter; DATA waits indefinitely for ahb_ready_in.

## Test plan
- SB addr 0x1003, rs2 0xAABBCCDD, ready=1 → dmaddr_out 0x1000, mask 1000, dmdata_out 0xDDDDDDDD, st_done_out at cycle N+3.
- SH addr 0x2002, rs2 0x12345678, ready low 2 cycles in DATA → mask 1100, data 0x56785678, done at N+5, busy high N+1..N+4.
- SW addr 0x3001 and SH addr 0x3001 → st_misalign_out N+1, dmwr_req_out never 1, busy 0.
- SW addr 0x4000 rs2 0xCAFEF00D, DATA ready=1 resp=1 → st_err_out pulse, st_done_out stays 0, IDLE.
- Two back-to-back aligned SW, second valid in done cycle → second accepted, two done pulses 3 cycles apart; rst_in asserted in DATA of a third → IDLE next cycle, no pulse.
- STORE_TIMEOUT_EN, TIMEOUT_CYCLES=4, ready held 0 in DATA → st_err_out after 4 wait cycles; without macro → stays DATA, busy 1.
